// File: rtl/rv_iopmp_pkg.sv
// Types shared by the IOPMP error-capture path: error/transaction encodings,
// the captured error record and the capture-stage FSM states.
package rv_iopmp_pkg;

    localparam int ERR_ADDR_W = 64;
    localparam int ERR_RRID_W = 16;
    localparam int ERR_EID_W  = 16;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_ILLEGAL_READ  = 3'd1,
        ERR_ILLEGAL_WRITE = 3'd2,
        ERR_ILLEGAL_FETCH = 3'd3,
        ERR_PARTIAL_HIT   = 3'd4,
        ERR_NOT_HIT       = 3'd5,
        ERR_RSVD6         = 3'd6,
        ERR_RSVD7         = 3'd7
    } err_type_e;

    typedef enum logic [1:0] {
        TT_RSVD  = 2'd0,
        TT_READ  = 2'd1,
        TT_WRITE = 2'd2,
        TT_FETCH = 2'd3
    } ttype_e;

    typedef struct packed {
        err_type_e              etype;
        ttype_e                 ttype;
        logic [ERR_RRID_W-1:0]  rrid;
        logic [ERR_EID_W-1:0]   eid;
        logic [ERR_ADDR_W-1:0]  addr;
    } err_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_RELOAD = 2'd2
    } cap_state_e;

endpackage

// File: rtl/rv_iopmp_err_fifo.sv
// Synchronous FIFO of error records; a push while full is accepted when a pop
// happens in the same cycle.
module rv_iopmp_err_fifo
    import rv_iopmp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  err_rec_t                   data_i,
    input  logic                       pop_i,
    output err_rec_t                   data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    err_rec_t           r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full_o    = (r_cnt == CNT_W'(DEPTH));
    assign empty_o   = (r_cnt == '0);
    assign w_pop_ok  = pop_i && !empty_o;
    assign w_push_ok = push_i && (!full_o || w_pop_ok);
    assign data_o    = r_mem[r_rptr];
    assign count_o   = r_cnt;

    // NOTE: the storage array has no reset; validity is tracked by r_cnt alone,
    // so clearing the entries would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/rv_iopmp_err_capture.sv
// IOPMP error-capture stage: holds the oldest violation in the error record,
// queues later ones, and drives the interrupt-pending level.
module rv_iopmp_err_capture
    import rv_iopmp_pkg::*;
#(
    parameter int ADDR_WIDTH  = ERR_ADDR_W,
    parameter int RRID_WIDTH  = ERR_RRID_W,
    parameter int EID_WIDTH   = ERR_EID_W,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           viol_valid_i,
    input  logic [2:0]                     viol_type_i,
    input  logic [1:0]                     viol_ttype_i,
    input  logic [RRID_WIDTH-1:0]          viol_rrid_i,
    input  logic [EID_WIDTH-1:0]           viol_eid_i,
    input  logic [ADDR_WIDTH-1:0]          viol_addr_i,
    input  logic                           ie_i,
    input  logic                           clr_i,
    input  logic                           ovf_clr_i,
    output logic                           err_v_o,
    output logic [2:0]                     err_type_o,
    output logic [1:0]                     err_ttype_o,
    output logic [RRID_WIDTH-1:0]          err_rrid_o,
    output logic [EID_WIDTH-1:0]           err_eid_o,
    output logic [ADDR_WIDTH-1:0]          err_addr_o,
    output logic                           intp_o,
    output logic                           ovf_o,
    output logic [$clog2(QUEUE_DEPTH):0]   qcnt_o
);

    cap_state_e r_state;
    cap_state_e w_state_nxt;
    err_rec_t   r_rec;
    logic       r_ovf;
    err_rec_t   w_viol_rec;
    err_rec_t   w_fifo_head;
    logic       w_push;
    logic       w_pop;
    logic       w_capture;
    logic       w_full;
    logic       w_empty;
    logic       w_drop;

    assign w_viol_rec = '{etype: err_type_e'(viol_type_i),
                          ttype: ttype_e'(viol_ttype_i),
                          rrid:  viol_rrid_i,
                          eid:   viol_eid_i,
                          addr:  viol_addr_i};

    rv_iopmp_err_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_viol_rec),
        .pop_i   (w_pop),
        .data_o  (w_fifo_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (qcnt_o)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_RELOAD;
                end else if (viol_valid_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                w_push = viol_valid_i;
                if (clr_i) begin
                    w_state_nxt = (!w_empty || w_push) ? ST_RELOAD : ST_IDLE;
                end
            end
            ST_RELOAD: begin
                w_push      = viol_valid_i;
                w_pop       = 1'b1;
                w_state_nxt = ST_HELD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_rec   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_rec <= w_viol_rec;
            end else if (w_pop) begin
                r_rec <= w_fifo_head;
            end
            // A drop in the same cycle as the software clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign err_v_o     = (r_state == ST_HELD);
    assign intp_o      = err_v_o & ie_i;
    assign ovf_o       = r_ovf;
    assign err_type_o  = r_rec.etype;
    assign err_ttype_o = r_rec.ttype;
    assign err_rrid_o  = r_rec.rrid;
    assign err_eid_o   = r_rec.eid;
    assign err_addr_o  = r_rec.addr;

    // Entering IDLE with queued records cannot happen: every clear with a
    // non-empty queue goes through RELOAD.
    a_idle_queue_empty: assert property (
        @(posedge clk_i) disable iff (!rst_ni) (r_state == ST_IDLE) |-> w_empty
    );

endmodule

// File: tb/tb_rv_iopmp_err_capture.sv
// Directed bench for rv_iopmp_err_capture: capture, queue reload, overflow,
// same-cycle clear+push, interrupt enable gating and asynchronous reset.
module tb_rv_iopmp_err_capture;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        viol_valid_i;
    logic [2:0]  viol_type_i;
    logic [1:0]  viol_ttype_i;
    logic [15:0] viol_rrid_i;
    logic [15:0] viol_eid_i;
    logic [63:0] viol_addr_i;
    logic        ie_i;
    logic        clr_i;
    logic        ovf_clr_i;
    logic        err_v_o;
    logic [2:0]  err_type_o;
    logic [1:0]  err_ttype_o;
    logic [15:0] err_rrid_o;
    logic [15:0] err_eid_o;
    logic [63:0] err_addr_o;
    logic        intp_o;
    logic        ovf_o;
    logic [2:0]  qcnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    rv_iopmp_err_capture #(
        .ADDR_WIDTH  (64),
        .RRID_WIDTH  (16),
        .EID_WIDTH   (16),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .viol_valid_i (viol_valid_i),
        .viol_type_i  (viol_type_i),
        .viol_ttype_i (viol_ttype_i),
        .viol_rrid_i  (viol_rrid_i),
        .viol_eid_i   (viol_eid_i),
        .viol_addr_i  (viol_addr_i),
        .ie_i         (ie_i),
        .clr_i        (clr_i),
        .ovf_clr_i    (ovf_clr_i),
        .err_v_o      (err_v_o),
        .err_type_o   (err_type_o),
        .err_ttype_o  (err_ttype_o),
        .err_rrid_o   (err_rrid_o),
        .err_eid_o    (err_eid_o),
        .err_addr_o   (err_addr_o),
        .intp_o       (intp_o),
        .ovf_o        (ovf_o),
        .qcnt_o       (qcnt_o)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_viol(input logic [15:0] rrid, input logic [63:0] addr);
        viol_valid_i = 1'b1;
        viol_type_i  = 3'd5;
        viol_ttype_i = 2'd1;
        viol_rrid_i  = rrid;
        viol_eid_i   = 16'd0;
        viol_addr_i  = addr;
    endtask

    initial begin
        rst_ni       = 1'b0;
        viol_valid_i = 1'b0;
        viol_type_i  = 3'd0;
        viol_ttype_i = 2'd0;
        viol_rrid_i  = 16'd0;
        viol_eid_i   = 16'd0;
        viol_addr_i  = 64'd0;
        ie_i         = 1'b1;
        clr_i        = 1'b0;
        ovf_clr_i    = 1'b0;
        tick();
        tick();
        check("rst_v",    err_v_o, 0);
        check("rst_intp", intp_o, 0);
        check("rst_ovf",  ovf_o, 0);
        check("rst_qcnt", qcnt_o, 0);
        check("rst_addr", err_addr_o, 0);
        rst_ni = 1'b1;
        tick();

        // Single violation captured with latency 1, then cleared back to IDLE.
        viol_valid_i = 1'b1;
        viol_type_i  = 3'd2;
        viol_ttype_i = 2'd2;
        viol_rrid_i  = 16'h0005;
        viol_eid_i   = 16'h0003;
        viol_addr_i  = 64'h8000_1000;
        tick();
        viol_valid_i = 1'b0;
        check("cap_v",     err_v_o, 1);
        check("cap_intp",  intp_o, 1);
        check("cap_type",  err_type_o, 2);
        check("cap_ttype", err_ttype_o, 2);
        check("cap_rrid",  err_rrid_o, 16'h0005);
        check("cap_eid",   err_eid_o, 16'h0003);
        check("cap_addr",  err_addr_o, 64'h8000_1000);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_v",     err_v_o, 0);
        check("clr_intp",  intp_o, 0);
        check("clr_hold",  err_addr_o, 64'h8000_1000);
        tick();
        check("idle_v",    err_v_o, 0);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("idle_clr_v", err_v_o, 0);

        // Three queued violations drained in order, each with a one-cycle gap.
        set_viol(16'h0010, 64'h1000);
        tick();
        for (int k = 1; k <= 3; k++) begin
            set_viol(16'h0010 + 16'(k), 64'h1000 + 64'(k));
            tick();
        end
        viol_valid_i = 1'b0;
        check("q3_qcnt", qcnt_o, 3);
        check("q3_rrid", err_rrid_o, 16'h0010);
        for (int k = 1; k <= 3; k++) begin
            clr_i = 1'b1;
            tick();
            clr_i = 1'b0;
            check("q_gap_v",  err_v_o, 0);
            tick();
            check("q_rel_v",    err_v_o, 1);
            check("q_rel_rrid", err_rrid_o, 16'h0010 + 16'(k));
            check("q_rel_qcnt", qcnt_o, 3 - k);
        end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();
        check("q_idle_v", err_v_o, 0);

        // Five pushes into a depth-4 queue: fifth dropped, overflow sticky.
        set_viol(16'h0020, 64'h2000);
        tick();
        for (int k = 1; k <= 5; k++) begin
            set_viol(16'h0020 + 16'(k), 64'h2000 + 64'(k));
            tick();
        end
        viol_valid_i = 1'b0;
        check("ovf_qcnt", qcnt_o, 4);
        check("ovf_set",  ovf_o, 1);
        tick();
        check("ovf_sticky", ovf_o, 1);
        set_viol(16'h0026, 64'h2006);
        ovf_clr_i = 1'b1;
        tick();
        viol_valid_i = 1'b0;
        ovf_clr_i    = 1'b0;
        check("ovf_set_wins", ovf_o, 1);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("ovf_clr", ovf_o, 0);
        for (int k = 1; k <= 4; k++) begin
            clr_i = 1'b1;
            tick();
            clr_i = 1'b0;
            tick();
            check("ovf_drain_rrid", err_rrid_o, 16'h0020 + 16'(k));
        end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();
        check("ovf_end_v",    err_v_o, 0);
        check("ovf_end_rrid", err_rrid_o, 16'h0024);
        check("ovf_end_qcnt", qcnt_o, 0);

        // Clear and push in the same HELD cycle with an empty queue.
        set_viol(16'h0030, 64'h3000);
        tick();
        set_viol(16'h0031, 64'h3001);
        clr_i = 1'b1;
        tick();
        viol_valid_i = 1'b0;
        clr_i        = 1'b0;
        check("cp_gap_v",  err_v_o, 0);
        check("cp_qcnt",   qcnt_o, 1);
        tick();
        check("cp_v",      err_v_o, 1);
        check("cp_rrid",   err_rrid_o, 16'h0031);
        check("cp_addr",   err_addr_o, 64'h3001);
        check("cp_qcnt0",  qcnt_o, 0);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();

        // Interrupt enable gates only the pending level.
        ie_i = 1'b0;
        set_viol(16'h0040, 64'h4000);
        tick();
        viol_valid_i = 1'b0;
        check("ie0_v",    err_v_o, 1);
        check("ie0_intp", intp_o, 0);
        ie_i = 1'b1;
        #1;
        check("ie1_intp", intp_o, 1);
        check("ie1_rrid", err_rrid_o, 16'h0040);

        // Asynchronous reset mid-cycle while HELD with two queued entries.
        set_viol(16'h0041, 64'h4001);
        tick();
        set_viol(16'h0042, 64'h4002);
        tick();
        viol_valid_i = 1'b0;
        check("pre_rst_qcnt", qcnt_o, 2);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_v",    err_v_o, 0);
        check("arst_intp", intp_o, 0);
        check("arst_qcnt", qcnt_o, 0);
        check("arst_ovf",  ovf_o, 0);
        check("arst_rrid", err_rrid_o, 0);
        check("arst_addr", err_addr_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        set_viol(16'h0050, 64'h5000);
        tick();
        viol_valid_i = 1'b0;
        check("post_rst_v",    err_v_o, 1);
        check("post_rst_rrid", err_rrid_o, 16'h0050);
        check("post_rst_qcnt", qcnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
